// File: rtl/num_split_seq.sv
// rtl/num_split_seq.sv - sequential binary-to-BCD splitter (double-dabble, one bit per clock)
// Saturates to all-9 digits and flags ovf when the value needs more than D digits.
module num_split_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   din,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           ovf
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4*D-1:0]   scr_q, scr_d;
  logic [W-1:0]     shf_q, shf_d;
  logic             sticky_q, sticky_d;
  logic [4*D-1:0]   bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [4*D-1:0]   adj;
  logic [4*D+W-1:0] cat;
  logic             carry;

  // Add-3 stays inside each nibble; a digit >= 8 after adjust spills out the top on the shift.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < D; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  assign cat   = {adj, shf_q} << 1;
  assign carry = adj[4*D-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scr_d    = scr_q;
    shf_d    = shf_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shf_d    = din;
          scr_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CW'(W);
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scr_d    = cat[4*D+W-1:W];
        shf_d    = cat[W-1:0];
        sticky_d = sticky_q | carry;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          bcd_d   = (sticky_q | carry) ? {D{4'h9}} : cat[4*D+W-1:W];
          ovf_d   = sticky_q | carry;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      scr_q    <= '0;
      shf_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scr_q    <= scr_d;
      shf_q    <= shf_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_num_split_seq.sv
// tb/tb_num_split_seq.sv - directed + random bench for num_split_seq with a result scoreboard
module tb_num_split_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_start, b_start, c_start;
  logic [7:0]  a_din, b_din;
  logic [15:0] c_din;
  logic        a_busy, a_done, a_ovf;
  logic        b_busy, b_done, b_ovf;
  logic        c_busy, c_done, c_ovf;
  logic [11:0] a_bcd;
  logic [7:0]  b_bcd;
  logic [19:0] c_bcd;

  int n_tests = 0;
  int n_fail  = 0;
  int a_dones = 0;
  logic [20:0] qa[$];
  logic [20:0] qb[$];
  logic [20:0] qc[$];
  logic [20:0] ea, eb, ec;

  num_split_seq #(.W(8), .D(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .din(a_din),
    .busy(a_busy), .done(a_done), .bcd(a_bcd), .ovf(a_ovf)
  );
  num_split_seq #(.W(8), .D(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .din(b_din),
    .busy(b_busy), .done(b_done), .bcd(b_bcd), .ovf(b_ovf)
  );
  num_split_seq #(.W(16), .D(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .din(c_din),
    .busy(c_busy), .done(c_done), .bcd(c_bcd), .ovf(c_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value split into d decimal digits, saturating to all nines above 10^d - 1.
  function automatic logic [20:0] exp_val(input int v, input int d);
    logic [20:0] r;
    int lim;
    int t;
    r   = '0;
    lim = 1;
    t   = v;
    for (int k = 0; k < d; k++) lim = lim * 10;
    if (v >= lim) begin
      r[20] = 1'b1;
      for (int k = 0; k < d; k++) r[4*k +: 4] = 4'h9;
    end else begin
      for (int k = 0; k < d; k++) begin
        r[4*k +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (a_done) begin
      a_dones++;
      chk("a_done_busy", {63'd0, a_busy}, 64'd0);
      if (qa.size() == 0) chk("a_unexpected_done", 64'd1, 64'd0);
      else begin
        ea = qa.pop_front();
        chk("a_result", {43'd0, a_ovf, 8'd0, a_bcd}, {43'd0, ea});
      end
    end
  end

  always @(negedge clk) begin
    if (b_done) begin
      chk("b_done_busy", {63'd0, b_busy}, 64'd0);
      if (qb.size() == 0) chk("b_unexpected_done", 64'd1, 64'd0);
      else begin
        eb = qb.pop_front();
        chk("b_result", {43'd0, b_ovf, 12'd0, b_bcd}, {43'd0, eb});
      end
    end
  end

  always @(negedge clk) begin
    if (c_done) begin
      chk("c_done_busy", {63'd0, c_busy}, 64'd0);
      if (qc.size() == 0) chk("c_unexpected_done", 64'd1, 64'd0);
      else begin
        ec = qc.pop_front();
        chk("c_result", {43'd0, c_ovf, c_bcd}, {43'd0, ec});
      end
    end
  end

  task automatic wait_done(input int sel, output int lat);
    int k;
    k = 0;
    while (!(sel == 0 ? a_done : (sel == 1 ? b_done : c_done)) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("wait_done_%0d", sel), {63'd0, k < 60}, 64'd1);
    lat = k;
  endtask

  task automatic conv(input int sel, input int v);
    int lat;
    @(negedge clk);
    case (sel)
      0: begin a_start = 1'b1; a_din = 8'(v);  qa.push_back(exp_val(v, 3)); end
      1: begin b_start = 1'b1; b_din = 8'(v);  qb.push_back(exp_val(v, 2)); end
      default: begin c_start = 1'b1; c_din = 16'(v); qc.push_back(exp_val(v, 5)); end
    endcase
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
    wait_done(sel, lat);
  endtask

  initial begin
    int lat;
    int d0;
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_din = '0; b_din = '0; c_din = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_done", {63'd0, a_done}, 64'd0);
    chk("rst_bcd",  {52'd0, a_bcd}, 64'd0);
    chk("rst_ovf",  {63'd0, a_ovf}, 64'd0);

    // 67: busy for exactly 8 cycles, done right after
    @(negedge clk);
    a_start = 1'b1; a_din = 8'd67; qa.push_back(exp_val(67, 3));
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lat_busy_%0d", i), {62'd0, a_busy, a_done}, 64'd2);
      @(negedge clk);
    end
    chk("lat_done", {62'd0, a_busy, a_done}, 64'd1);

    // start held high across the done cycle restarts with the new din
    @(negedge clk);
    a_start = 1'b1; a_din = 8'd255; qa.push_back(exp_val(255, 3));
    @(negedge clk);
    a_din = 8'd0; qa.push_back(exp_val(0, 3));
    wait_done(0, lat);
    chk("b2b_lat", 64'(lat), 64'd8);
    @(negedge clk);
    a_start = 1'b0;
    wait_done(0, lat);
    chk("b2b_gap", 64'(lat + 1), 64'd9);

    // start during busy is ignored
    @(negedge clk);
    a_start = 1'b1; a_din = 8'd42; qa.push_back(exp_val(42, 3));
    d0 = a_dones;
    @(negedge clk);
    a_start = 1'b0;
    repeat (2) @(negedge clk);
    a_start = 1'b1; a_din = 8'd200;
    @(negedge clk);
    a_start = 1'b0;
    wait_done(0, lat);
    repeat (12) @(negedge clk);
    chk("ign_one_done", 64'(a_dones - d0), 64'd1);

    // reset mid-conversion aborts everything
    @(negedge clk);
    a_start = 1'b1; a_din = 8'd180;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, a_busy}, 64'd0);
    chk("abort_done", {63'd0, a_done}, 64'd0);
    chk("abort_bcd",  {52'd0, a_bcd}, 64'd0);
    chk("abort_ovf",  {63'd0, a_ovf}, 64'd0);
    d0 = a_dones;
    repeat (15) @(negedge clk);
    chk("abort_no_done", 64'(a_dones - d0), 64'd0);
    conv(0, 7);

    // two-digit instance: edge of range and overflow saturation
    conv(1, 99);
    conv(1, 100);
    conv(1, 123);
    chk("b_ovf_hold", {63'd0, b_ovf}, 64'd1);
    for (int i = 0; i < 6; i++) conv(1, int'($urandom_range(0, 255)));

    conv(2, 65535);
    for (int i = 0; i < 8; i++) conv(2, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 6; i++) conv(0, int'($urandom_range(0, 255)));

    repeat (3) @(negedge clk);
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    chk("qc_empty", 64'(qc.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
